// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester bridging a valid/ready command port to APB SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pselect,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t r_state;
  logic   w_accept, w_done, w_abort;
  assign cmd_ready = (r_state == IDLE) || (r_state == ACCESS && pready);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_done    = (r_state == ACCESS) && pready;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] LP_LIM = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_cnt;
  // abort on the edge that would record the TIMEOUT_CYCLES-th stalled ACCESS cycle
  assign w_abort = (r_state == ACCESS) && !pready && (r_cnt == LP_LIM);
  always_ff @(posedge pclk) begin
    if (preset) r_cnt <= '0;
    else r_cnt <= w_accept ? '0 : (r_state == ACCESS && !pready) ? r_cnt + 8'd1 : r_cnt;
  end
`else
  assign w_abort = 1'b0;
`endif
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= IDLE;
      paddr       <= '0;
      pselect     <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rsp_valid   <= w_done || w_abort;
      rsp_timeout <= w_abort;
      if (w_done) begin
        rsp_rdata  <= pwrite ? '0 : prdata;
        rsp_slverr <= pslverr;
      end else if (w_abort) begin
        rsp_rdata  <= '0;
        rsp_slverr <= 1'b1;
      end
      if (w_accept) begin
        r_state <= SETUP;
        paddr   <= cmd_addr;
        pwrite  <= cmd_write;
        pwdata  <= cmd_write ? cmd_wdata : '0;
        pselect <= 1'b1;
        penable <= 1'b0;
        busy    <= 1'b1;
      end else if (r_state == SETUP) begin
        r_state <= ACCESS;
        penable <= 1'b1;
      end else if (w_done || w_abort) begin
        r_state <= IDLE;
        pselect <= 1'b0;
        penable <= 1'b0;
        busy    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master.
module tb_apb_master;
  logic        pclk = 1'b0;
  logic        preset, cmd_valid, cmd_write, pready, pslverr;
  logic [7:0]  cmd_addr, paddr;
  logic [31:0] cmd_wdata, pwdata, prdata, rsp_rdata;
  logic        cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, busy, pselect, penable, pwrite;
  int          n_assert = 0, n_fail = 0, seen;

  apb_master dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout), .busy(busy), .paddr(paddr), .pselect(pselect),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic ck();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic w, input logic [7:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    ck(); ck();
    chk("rst_psel", pselect, 0); chk("rst_pen", penable, 0); chk("rst_rspv", rsp_valid, 0);
    chk("rst_busy", busy, 0); chk("rst_paddr", paddr, 0); chk("rst_pwdata", pwdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1); chk("rst_timeout", rsp_timeout, 0);
    preset = 1'b0;

    // zero-wait write
    cmd(1'b1, 8'h10, 32'hDEADBEEF);
    ck(); cmd_valid = 1'b0; pready = 1'b1;
    chk("wr_setup_psel", pselect, 1); chk("wr_setup_pen", penable, 0);
    chk("wr_paddr", paddr, 8'h10); chk("wr_pwrite", pwrite, 1);
    chk("wr_pwdata", pwdata, 32'hDEADBEEF); chk("wr_busy", busy, 1); chk("wr_setup_ready", cmd_ready, 0);
    ck();
    chk("wr_access_pen", penable, 1); chk("wr_access_rspv", rsp_valid, 0); chk("wr_access_ready", cmd_ready, 1);
    ck(); pready = 1'b0;
    chk("wr_rspv", rsp_valid, 1); chk("wr_slverr", rsp_slverr, 0); chk("wr_rdata", rsp_rdata, 0);
    chk("wr_done_psel", pselect, 0); chk("wr_done_busy", busy, 0);
    ck();
    chk("wr_rspv_pulse", rsp_valid, 0);

    // read with three wait states
    cmd(1'b0, 8'h24, 32'h12345678);
    ck(); cmd_valid = 1'b0;
    chk("rd_pwrite", pwrite, 0); chk("rd_pwdata_zero", pwdata, 0);
    ck();
    chk("rd_access_pen", penable, 1);
    for (int i = 0; i < 3; i++) begin
      ck();
      chk("rd_wait_paddr", paddr, 8'h24); chk("rd_wait_pen", penable, 1); chk("rd_wait_rspv", rsp_valid, 0);
    end
    pready = 1'b1; prdata = 32'hA5A50001;
    ck(); pready = 1'b0; prdata = '0;
    chk("rd_rspv", rsp_valid, 1); chk("rd_rdata", rsp_rdata, 32'hA5A50001); chk("rd_slverr", rsp_slverr, 0);

    // back-to-back write then read
    ck();
    cmd(1'b1, 8'h04, 32'h11223344); pready = 1'b1;
    ck();
    chk("b2b_s1_psel", pselect, 1); chk("b2b_s1_pen", penable, 0);
    cmd(1'b0, 8'h04, 32'h0);
    ck();
    chk("b2b_a1_psel", pselect, 1); chk("b2b_a1_pen", penable, 1); chk("b2b_a1_pwrite", pwrite, 1);
    ck(); cmd_valid = 1'b0; prdata = 32'hCAFEF00D;
    chk("b2b_rsp1", rsp_valid, 1); chk("b2b_rsp1_rdata", rsp_rdata, 0);
    chk("b2b_s2_psel", pselect, 1); chk("b2b_s2_pen", penable, 0);
    chk("b2b_s2_pwrite", pwrite, 0); chk("b2b_s2_pwdata", pwdata, 0);
    ck();
    chk("b2b_a2_psel", pselect, 1); chk("b2b_a2_pen", penable, 1); chk("b2b_gap_rspv", rsp_valid, 0);
    ck(); pready = 1'b0; prdata = '0;
    chk("b2b_rsp2", rsp_valid, 1); chk("b2b_rsp2_rdata", rsp_rdata, 32'hCAFEF00D); chk("b2b_end_psel", pselect, 0);

    // slave error then clean transfer
    ck();
    cmd(1'b0, 8'h3C, 32'h0); pready = 1'b1; pslverr = 1'b1;
    ck(); cmd_valid = 1'b0;
    ck();
    ck(); pslverr = 1'b0;
    chk("err_rspv", rsp_valid, 1); chk("err_slverr", rsp_slverr, 1);
    cmd(1'b1, 8'h08, 32'h55AA55AA);
    ck(); cmd_valid = 1'b0;
    ck();
    ck(); pready = 1'b0;
    chk("clean_rspv", rsp_valid, 1); chk("clean_slverr", rsp_slverr, 0);

    // reset in the middle of ACCESS
    ck();
    cmd(1'b0, 8'h30, 32'h0);
    ck(); cmd_valid = 1'b0;
    ck(); ck();
    chk("mid_pen", penable, 1);
    preset = 1'b1; cmd_valid = 1'b1;
    ck(); preset = 1'b0; cmd_valid = 1'b0;
    chk("mrst_psel", pselect, 0); chk("mrst_pen", penable, 0); chk("mrst_busy", busy, 0);
    chk("mrst_rspv", rsp_valid, 0); chk("mrst_paddr", paddr, 0); chk("mrst_ready", cmd_ready, 1);
    ck();
    chk("mrst_no_accept", pselect, 0); chk("mrst_no_rsp", rsp_valid, 0);

    // stuck slave
    cmd(1'b0, 8'h40, 32'h0);
    ck(); cmd_valid = 1'b0;
    ck();
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      ck();
      chk("to_wait_pen", penable, 1); chk("to_wait_rspv", rsp_valid, 0);
    end
    cmd_valid = 1'b1; cmd_write = 1'b1;
    chk("to_abort_ready", cmd_ready, 0);
    ck(); cmd_valid = 1'b0;
    chk("to_rspv", rsp_valid, 1); chk("to_slverr", rsp_slverr, 1); chk("to_flag", rsp_timeout, 1);
    chk("to_rdata", rsp_rdata, 0); chk("to_psel", pselect, 0); chk("to_pen", penable, 0);
    ck();
    chk("to_rspv_pulse", rsp_valid, 0); chk("to_flag_pulse", rsp_timeout, 0); chk("to_no_accept", pselect, 0);
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      ck();
      if (rsp_valid) seen++;
    end
    chk("stuck_no_rsp", seen, 0); chk("stuck_psel", pselect, 1);
    chk("stuck_pen", penable, 1); chk("stuck_timeout", rsp_timeout, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
